// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - burst round-robin arbiter sharing one FIFO write port
// Optional source tag output enabled by FIFO_ARBITER_SOURCE_TAG_EN.
module fifo_write_arbiter #(
    parameter int WIDTH      = 8,
    parameter int REQUESTERS = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [REQUESTERS-1:0]           req_valid,
    output logic [REQUESTERS-1:0]           req_ready,
    input  logic [REQUESTERS*WIDTH-1:0]     req_data,
    input  logic [REQUESTERS-1:0]           req_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            out_almost_full,
`ifdef FIFO_ARBITER_SOURCE_TAG_EN
    output logic [$clog2(REQUESTERS)-1:0]   out_source,
`endif
    output logic                            grant_active,
    output logic [$clog2(REQUESTERS)-1:0]   grant_index
);

    localparam int IDX_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  pointer;
    logic [IDX_W-1:0]  pointer_next;
    logic [IDX_W-1:0]  grant_index_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_index;
    int                pick_probe;

    logic              holder_valid;
    logic              holder_last;
    logic [WIDTH-1:0]  holder_data;
    logic              holder_ready;
    logic              holder_xfer;
    logic              burst_done;
    logic [IDX_W-1:0]  pointer_after_holder;

    // The output register can take a word whenever it is empty or draining this cycle.
    assign holder_ready = (state == GRANT) && (!out_valid || out_ready);
    assign holder_xfer  = holder_ready && holder_valid;
    assign burst_done   = holder_last || (count == CNT_W'(MAX_BURST - 1));
    assign grant_active = (state == GRANT);

    assign pointer_after_holder = (grant_index == IDX_W'(REQUESTERS - 1)) ? '0
                                                                          : grant_index + 1'b1;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_index = '0;
        pick_probe = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            pick_probe = int'(pointer) + k;
            if (pick_probe >= REQUESTERS) begin
                pick_probe = pick_probe - REQUESTERS;
            end
            if (!pick_found && req_valid[pick_probe]) begin
                pick_found = 1'b1;
                pick_index = IDX_W'(pick_probe);
            end
        end
    end

    always_comb begin
        holder_valid = 1'b0;
        holder_last  = 1'b0;
        holder_data  = '0;
        req_ready    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_index == IDX_W'(i)) begin
                holder_valid = req_valid[i];
                holder_last  = req_last[i];
                holder_data  = req_data[i*WIDTH +: WIDTH];
                req_ready[i] = holder_ready;
            end
        end
    end

    always_comb begin
        state_next       = state;
        pointer_next     = pointer;
        count_next       = count;
        grant_index_next = grant_index;
        case (state)
            IDLE: begin
                if (pick_found && !out_almost_full) begin
                    state_next       = GRANT;
                    grant_index_next = pick_index;
                    count_next       = '0;
                end
            end
            GRANT: begin
                if (holder_xfer) begin
                    count_next = count + 1'b1;
                end
                // A holder that stops presenting data forfeits the port immediately.
                if (!holder_valid || (holder_xfer && burst_done)) begin
                    state_next   = IDLE;
                    pointer_next = pointer_after_holder;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pointer     <= '0;
            count       <= '0;
            grant_index <= '0;
        end else begin
            state       <= state_next;
            pointer     <= pointer_next;
            count       <= count_next;
            grant_index <= grant_index_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
`ifdef FIFO_ARBITER_SOURCE_TAG_EN
            out_source <= '0;
`endif
        end else if (holder_xfer) begin
            out_valid  <= 1'b1;
            out_data   <= holder_data;
`ifdef FIFO_ARBITER_SOURCE_TAG_EN
            out_source <= grant_index;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of a FIFO (typically the `in_*` side of `async_fifo`) between several requester streams in the write clock domain. Grants are burst-oriented: a requester keeps the port until it marks its last word, hits the burst limit, or stops presenting data. The output is one registered valid/ready stage, and no new grant starts while the FIFO reports almost-full.

## Interface
- `WIDTH`, 8, data word width
- `REQUESTERS`, 4, number of requester streams; must be ≥ 2
- `MAX_BURST`, 16, maximum words per grant; must be ≥ 1
- `clock`  input  1  single clock; all logic is on its rising edge
- `reset`  input  1  asynchronous, active-high
- `req_valid`  input  REQUESTERS  per-requester word valid
- `req_ready`  output  REQUESTERS  per-requester word accepted
- `req_data`  input  REQUESTERS*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- `req_last`  input  REQUESTERS  final word of the requester's burst; sampled with `req_valid`
- `out_valid`  output  1  word available to the FIFO
- `out_ready`  input  1  FIFO accepts the word
- `out_data`  output  WIDTH  word to the FIFO
- `out_almost_full`  input  1  FIFO almost-full status; blocks new grants
- `grant_active`  output  1  a requester currently holds the port
- `grant_index`  output  $clog2(REQUESTERS)  index of the holding or most recent requester

## Operation
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `req_ready`=0, `grant_active`=0, `grant_index`=0.
  - Round-robin pointer=0, burst count=0, state=IDLE.
- **Transfer rules:**
  - A requester-side transfer happens when `req_valid[i] && req_ready[i]`.
  - An output-side transfer happens when `out_valid && out_ready`.
- **IDLE:**
  - `req_ready`=0.
  - If any `req_valid` is high and `out_almost_full`=0, select the first i with `req_valid[i]`=1, searching upward from the pointer with wrap-around.
  - Then set `grant_index`=i, `grant_active`=1, count=0, and go to GRANT.
- **GRANT (holder g):**
  - `req_ready[g] = !out_valid || out_ready`, combinational. All other `req_ready` bits stay 0.
  - On each transfer, register `req_data[g]` into `out_data`, set `out_valid`=1, and increment count.
  - Release the grant when any of these holds:
    - the transferred word has `req_last[g]`=1;
    - count reaches MAX_BURST with this word;
    - `req_valid[g]`=0 in any GRANT cycle.
  - On release: go to IDLE, `grant_active`=0, pointer = (g+1) mod REQUESTERS. `grant_index` holds g.
- **Output stage:**
  - `out_valid` clears on an output transfer that has no new requester transfer in the same cycle.
  - A requester transfer and an output transfer may occur in the same cycle; this gives full throughput.
  - `out_valid` and `out_data` are never changed while `out_valid && !out_ready`.
- `out_almost_full` only gates grant start. An active grant continues and is throttled by `out_ready` alone.
- Word order within a grant is preserved. Words from different grants never interleave.

## Timing
- Requester word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N. Latency is 1 cycle.
- IDLE→GRANT takes 1 cycle. The first `req_ready` rises in the cycle after the arbitration decision.
- Release→IDLE→next GRANT leaves at least 1 dead cycle on `req_ready` between grants.
- Sustained throughput within a grant: 1 word/cycle while `out_ready`=1.
- Reset asserted mid-burst:
  - All outputs take their reset values immediately (asynchronously).
  - The pending `out_data` word is discarded.
  - The pointer returns to 0.

## Configuration
- `FIFO_ARBITER_SOURCE_TAG_EN`:
  - **Defined:** adds output `out_source`, width $clog2(REQUESTERS), reset 0. It is registered together with `out_data` on every requester transfer, carries the index of the requester that supplied the word, and is held stable under backpressure.
  - **Not defined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Single requester:**
  - Stimulus: requester 2 sends 0x11, 0x22, 0x33 with `req_last` on 0x33; `out_ready`=1.
  - Required: `out_data` shows 0x11/0x22/0x33 on consecutive cycles; `grant_index`=2; pointer becomes 3.
- **Round-robin:**
  - Stimulus: all 4 requesters continuously valid with single-word bursts (`req_last`=1).
  - Required: grant order 0,1,2,3,0; one dead cycle between grants.
- **Burst limit:**
  - Stimulus: MAX_BURST=4; requester 1 streams 10 words without `req_last`; requester 3 is also valid.
  - Required: requester 1 gets 4 words, then requester 3 is granted, then requester 1 resumes with word 5.
- **Backpressure and almost-full:**
  - Stimulus: hold `out_ready`=0 for 5 cycles mid-burst, then raise `out_almost_full` at burst end.
  - Required: `out_data`/`out_valid` stay stable during the stall, with no loss or duplication. No new grant while `out_almost_full`=1; a grant starts 1 cycle after it drops.
- **Abandon and reset:**
  - Stimulus: requester 0 drops `req_valid` after 2 of 5 words.
  - Required: grant released; next valid requester granted.
  - Stimulus: assert `reset` mid-burst.
  - Required: `out_valid`=0, `req_ready`=0, `grant_active`=0 immediately; after release, the first grant goes to the lowest valid index.
- **Tag (with `FIFO_ARBITER_SOURCE_TAG_EN`):**
  - Required: `out_source` equals the supplying index on every output word in the round-robin scenario.
